// File: rtl/game_pkg.sv
// Shared constants, tile encodings, FSM encoding and pixel/tile helpers for the
// player physics engine.
package game_pkg;

   localparam int TILE_SIZE = 32;
   localparam int MAP_COLS  = 20;
   localparam int MAP_ROWS  = 15;
   localparam int SCREEN_W  = 640;
   localparam int SCREEN_H  = 480;

   // Legal position range for the sprite (X left edge, Y bottom edge).
   localparam int X_MAX = SCREEN_W - TILE_SIZE;
   localparam int Y_MAX = SCREEN_H - 1;
   localparam int Y_MIN = TILE_SIZE - 1;

   typedef enum logic [2:0] {
      TILE_AIR    = 3'd0,
      TILE_GROUND = 3'd1,
      TILE_BRICK  = 3'd2,
      TILE_BLOCK  = 3'd3
   } tile_t;

   // Bit positions inside player_col.
   localparam int COL_LEFT  = 0;
   localparam int COL_DOWN  = 1;
   localparam int COL_RIGHT = 2;
   localparam int COL_UP    = 3;

   localparam logic [3:0] ST_IDLE   = 4'd0;
   localparam logic [3:0] ST_VEL    = 4'd1;
   localparam logic [3:0] ST_HP0    = 4'd2;
   localparam logic [3:0] ST_HP1    = 4'd3;
   localparam logic [3:0] ST_HW     = 4'd4;
   localparam logic [3:0] ST_HRES   = 4'd5;
   localparam logic [3:0] ST_VP0    = 4'd6;
   localparam logic [3:0] ST_VP1    = 4'd7;
   localparam logic [3:0] ST_VW     = 4'd8;
   localparam logic [3:0] ST_VRES   = 4'd9;
   localparam logic [3:0] ST_COMMIT = 4'd10;

   // Pixel coordinate to tile column / row.
   function automatic logic [4:0] to_col(input logic [9:0] px);
      return 5'(px >> 5);
   endfunction

   function automatic logic [3:0] to_row(input logic [9:0] px);
      return 4'(px >> 5);
   endfunction

endpackage

// File: rtl/player_physics_if.sv
// Tile store read port: request strobe plus address, data one cycle later.
interface player_physics_if;
   import game_pkg::*;

   logic       tile_req;
   logic [4:0] tile_col;
   logic [3:0] tile_row;
   logic [2:0] tile_type;

   modport master (output tile_req, output tile_col, output tile_row, input tile_type);
   modport slave  (input tile_req, input tile_col, input tile_row, output tile_type);

endinterface

// File: rtl/player_physics_tile_probe.sv
// Two back-to-back tile reads; reports whether either tile is solid and which
// tile was hit first. Row MAP_ROWS (just below the screen) always counts as solid.
module tile_probe
   import game_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    first,
   input  logic                    second,
   input  logic [4:0]              col,
   input  logic [3:0]              row,
   player_physics_if.master        tile,
   output logic                    hit,
   output logic [4:0]              hit_col,
   output logic [3:0]              hit_row
);

   logic       pend;
   logic       pend_first;
   logic [4:0] pend_col;
   logic [3:0] pend_row;
   logic       solid;

   assign tile.tile_req = first | second;
   assign tile.tile_col = col;
   assign tile.tile_row = row;

   assign solid = pend && ((tile.tile_type != TILE_AIR) || (pend_row == 4'(MAP_ROWS)));

   // Remember each request and fold its response into the hit result;
   // the first response restarts the result, the second can only add a hit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend       <= 1'b0;
         pend_first <= 1'b0;
         pend_col   <= '0;
         pend_row   <= '0;
         hit        <= 1'b0;
         hit_col    <= '0;
         hit_row    <= '0;
      end else begin
         pend       <= first | second;
         pend_first <= first;
         pend_col   <= col;
         pend_row   <= row;
         if (pend && (pend_first || !hit)) begin
            hit     <= solid;
            hit_col <= pend_col;
            hit_row <= pend_row;
         end
      end
   end

endmodule

// File: rtl/player_physics.sv
// Per-frame player motion and tile collision engine. Integrates buttons and
// gravity, probes the tile map horizontally then vertically, and commits the
// new position and collision flags together.
module player_physics
   import game_pkg::*;
#(
   parameter int START_X  = 32,
   parameter int START_Y  = 447,
   parameter int SPEED    = 2,
   parameter int JUMP_V   = 10,
   parameter int GRAVITY  = 1,
   parameter int MAX_FALL = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             frame_start,
   input  logic             btn_left,
   input  logic             btn_right,
   input  logic             btn_jump,
   player_physics_if.master tile,
   output logic [19:0]      player_pos,
   output logic [3:0]       player_col,
   output logic             busy
);

   localparam logic signed [10:0] SPEED_S = 11'(SPEED);
   localparam logic signed [7:0]  JUMP_S  = 8'(JUMP_V);
   localparam logic signed [7:0]  GRAV_S  = 8'(GRAVITY);
   localparam logic signed [7:0]  FALL_S  = 8'(MAX_FALL);

   logic [3:0]         state;
   logic [3:0]         state_nx;
   logic [9:0]         pos_x;
   logic [9:0]         pos_y;
   logic signed [7:0]  vy;
   logic signed [10:0] vx;
   logic [9:0]         x_w;
   logic [9:0]         y_w;
   logic [3:0]         flags_w;
   logic               vneg;

   logic signed [10:0] vx_in;
   logic signed [10:0] x_sum;
   logic signed [7:0]  vy_sum;
   logic signed [7:0]  vy_next;
   logic signed [11:0] y_sum;

   logic               probe_first;
   logic               probe_second;
   logic [4:0]         req_col;
   logic [3:0]         req_row;
   logic [4:0]         hcol;
   logic [3:0]         vrow;
   logic               hit;
   logic [4:0]         hit_col;
   logic [3:0]         hit_row;

   assign player_pos = {pos_x, pos_y};
   assign busy       = (state != ST_IDLE);

   // Linear walk through the frame; only IDLE waits for an event.
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:   if (frame_start) state_nx = ST_VEL;
         ST_COMMIT: state_nx = ST_IDLE;
         default:   state_nx = (state < ST_COMMIT) ? state + 4'd1 : ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nx;
   end

   // Velocity and tentative position arithmetic.
   always_comb begin
      vx_in = '0;
      if (btn_right && !btn_left)      vx_in = SPEED_S;
      else if (btn_left && !btn_right) vx_in = -SPEED_S;
      x_sum  = $signed({1'b0, pos_x}) + vx_in;
      vy_sum = vy + GRAV_S;
      if (btn_jump && player_col[COL_DOWN]) vy_next = -JUMP_S;
      else if (vy_sum > FALL_S)             vy_next = FALL_S;
      else                                  vy_next = vy_sum;
      y_sum = $signed({2'b00, pos_y}) + $signed({{4{vy[7]}}, vy});
   end

   // Probe addresses: leading edge column for horizontal, leading edge row for vertical.
   always_comb begin
      hcol         = (vx > 11'sd0) ? to_col(x_w + 10'(TILE_SIZE - 1)) : to_col(x_w);
      vrow         = vneg ? to_row(y_w - 10'(Y_MIN)) : to_row(y_w + 10'd1);
      probe_first  = 1'b0;
      probe_second = 1'b0;
      req_col      = '0;
      req_row      = '0;
      case (state)
         ST_HP0: begin
            probe_first = 1'b1;
            req_col     = hcol;
            req_row     = to_row(pos_y - 10'(Y_MIN));
         end
         ST_HP1: begin
            probe_second = 1'b1;
            req_col      = hcol;
            req_row      = to_row(pos_y);
         end
         ST_VP0: begin
            probe_first = 1'b1;
            req_col     = to_col(x_w);
            req_row     = vrow;
         end
         ST_VP1: begin
            probe_second = 1'b1;
            req_col      = to_col(x_w + 10'(TILE_SIZE - 1));
            req_row      = vrow;
         end
         default: ;
      endcase
   end

   tile_probe u_probe (
      .clk     (clk),
      .rst_n   (rst_n),
      .first   (probe_first),
      .second  (probe_second),
      .col     (req_col),
      .row     (req_row),
      .tile    (tile),
      .hit     (hit),
      .hit_col (hit_col),
      .hit_row (hit_row)
   );

   // Per-state datapath: velocity, clamping, collision resolution and commit.
   // The vertical Y' is formed in HRES alongside the horizontal resolution since
   // it does not depend on X; vneg keeps the pre-clamp direction for the probe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pos_x      <= 10'(START_X);
         pos_y      <= 10'(START_Y);
         player_col <= '0;
         vy         <= '0;
         vx         <= '0;
         x_w        <= '0;
         y_w        <= '0;
         flags_w    <= '0;
         vneg       <= 1'b0;
      end else begin
         case (state)
            ST_VEL: begin
               vy      <= vy_next;
               vx      <= vx_in;
               flags_w <= '0;
               if (x_sum < 0) begin
                  x_w               <= '0;
                  flags_w[COL_LEFT] <= 1'b1;
               end else if (x_sum > X_MAX) begin
                  x_w                <= 10'(X_MAX);
                  flags_w[COL_RIGHT] <= 1'b1;
               end else begin
                  x_w <= 10'(x_sum);
               end
            end
            ST_HRES: begin
               if (vx > 11'sd0) begin
                  if (hit) begin
                     x_w                <= {hit_col, 5'b00000} - 10'(TILE_SIZE);
                     flags_w[COL_RIGHT] <= 1'b1;
                  end
               end else if (vx < 11'sd0) begin
                  if (hit) begin
                     x_w               <= {5'(hit_col + 5'd1), 5'b00000};
                     flags_w[COL_LEFT] <= 1'b1;
                  end
               end else begin
                  flags_w[COL_RIGHT] <= 1'b0;
                  flags_w[COL_LEFT]  <= 1'b0;
               end
               vneg <= vy[7];
               if (y_sum > Y_MAX) begin
                  y_w               <= 10'(Y_MAX);
                  flags_w[COL_DOWN] <= 1'b1;
                  vy                <= '0;
               end else if (y_sum < Y_MIN) begin
                  y_w             <= 10'(Y_MIN);
                  flags_w[COL_UP] <= 1'b1;
                  vy              <= '0;
               end else begin
                  y_w <= 10'(y_sum);
               end
            end
            ST_VRES: begin
               if (hit) begin
                  vy <= '0;
                  if (!vneg) begin
                     y_w               <= {1'b0, hit_row, 5'b00000} - 10'd1;
                     flags_w[COL_DOWN] <= 1'b1;
                  end else begin
                     y_w             <= {1'b0, 4'(hit_row + 4'd1), 5'b00000} + 10'(Y_MIN);
                     flags_w[COL_UP] <= 1'b1;
                  end
               end
            end
            ST_COMMIT: begin
               pos_x      <= x_w;
               pos_y      <= y_w;
               player_col <= flags_w;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_player_physics.sv
// Directed bench for player_physics with a behavioural one-cycle tile store.
module tb_player_physics;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        frame_start = 1'b0;
   logic        btn_left = 1'b0;
   logic        btn_right = 1'b0;
   logic        btn_jump = 1'b0;
   logic [19:0] player_pos;
   logic [3:0]  player_col;
   logic        busy;
   logic [9:0]  px;
   logic [9:0]  py;

   logic [2:0]  map [0:14][0:19];
   int          checks = 0;
   int          passed = 0;

   player_physics_if tile_bus();

   player_physics #(
      .START_X  (32),
      .START_Y  (447),
      .SPEED    (2),
      .JUMP_V   (10),
      .GRAVITY  (1),
      .MAX_FALL (8)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_start (frame_start),
      .btn_left    (btn_left),
      .btn_right   (btn_right),
      .btn_jump    (btn_jump),
      .tile        (tile_bus),
      .player_pos  (player_pos),
      .player_col  (player_col),
      .busy        (busy)
   );

   assign px = player_pos[19:10];
   assign py = player_pos[9:0];

   always #5 clk = ~clk;

   // Tile store: registered read, air outside the map.
   always @(posedge clk) begin
      if (tile_bus.tile_req && tile_bus.tile_row < 4'd15 && tile_bus.tile_col < 5'd20)
         tile_bus.tile_type <= map[tile_bus.tile_row][tile_bus.tile_col];
      else
         tile_bus.tile_type <= 3'd0;
   end

   task automatic clear_map();
      for (int r = 0; r < 15; r++)
         for (int c = 0; c < 20; c++)
            map[r][c] = 3'd0;
   endtask

   task automatic set_floor();
      for (int c = 0; c < 20; c++) map[14][c] = 3'd1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      frame_start = 1'b0;
      btn_left = 1'b0;
      btn_right = 1'b0;
      btn_jump = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic run_frame(input logic l, input logic r, input logic j);
      @(negedge clk);
      btn_left = l;
      btn_right = r;
      btn_jump = j;
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      repeat (11) @(negedge clk);
      btn_left = 1'b0;
      btn_right = 1'b0;
      btn_jump = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (player_pos !== {10'd32, 10'd447}) $display("FAIL reset_pos got %h expected %h", player_pos, {10'd32, 10'd447});
      else passed++;
      checks++;
      if (player_col !== 4'b0000) $display("FAIL reset_col got %b expected 0000", player_col);
      else passed++;
      checks++;
      if (busy !== 1'b0) $display("FAIL reset_busy got %b expected 0", busy);
      else passed++;
      checks++;
      if (tile_bus.tile_req !== 1'b0) $display("FAIL reset_req got %b expected 0", tile_bus.tile_req);
      else passed++;
      checks++;
      if (tile_bus.tile_col !== 5'd0) $display("FAIL reset_tcol got %0d expected 0", tile_bus.tile_col);
      else passed++;
      checks++;
      if (tile_bus.tile_row !== 4'd0) $display("FAIL reset_trow got %0d expected 0", tile_bus.tile_row);
      else passed++;
   endtask

   task automatic test_freefall();
      clear_map();
      do_reset();
      run_frame(1'b0, 1'b0, 1'b0);
      checks++;
      if (py !== 10'd448) $display("FAIL fall_f1_y got %0d expected 448", py);
      else passed++;
      repeat (6) run_frame(1'b0, 1'b0, 1'b0);
      checks++;
      if ({py, player_col} !== {10'd475, 4'b0000}) $display("FAIL fall_f7 got y=%0d col=%b expected y=475 col=0000", py, player_col);
      else passed++;
      run_frame(1'b0, 1'b0, 1'b0);
      checks++;
      if ({py, player_col} !== {10'd479, 4'b0010}) $display("FAIL fall_f8 got y=%0d col=%b expected y=479 col=0010", py, player_col);
      else passed++;
      repeat (32) run_frame(1'b0, 1'b0, 1'b0);
      checks++;
      if ({px, py, player_col} !== {10'd32, 10'd479, 4'b0010})
         $display("FAIL fall_f40 got x=%0d y=%0d col=%b expected x=32 y=479 col=0010", px, py, player_col);
      else passed++;
   endtask

   task automatic test_walk_floor();
      clear_map();
      set_floor();
      do_reset();
      for (int unsigned f = 1; f <= 10; f++) begin
         run_frame(1'b0, 1'b1, 1'b0);
         checks++;
         if ({py, player_col} !== {10'd447, 4'b0010})
            $display("FAIL walk_frame%0d got y=%0d col=%b expected y=447 col=0010", f, py, player_col);
         else passed++;
      end
      checks++;
      if (px !== 10'd52) $display("FAIL walk_x got %0d expected 52", px);
      else passed++;
   endtask

   task automatic test_jump();
      clear_map();
      set_floor();
      do_reset();
      run_frame(1'b0, 1'b0, 1'b0);
      run_frame(1'b0, 1'b0, 1'b1);
      checks++;
      if ({py, player_col} !== {10'd437, 4'b0000}) $display("FAIL jump_f1 got y=%0d col=%b expected y=437 col=0000", py, player_col);
      else passed++;
      run_frame(1'b0, 1'b0, 1'b0);
      checks++;
      if (py !== 10'd428) $display("FAIL jump_f2_y got %0d expected 428", py);
      else passed++;
      repeat (18) run_frame(1'b0, 1'b0, 1'b0);
      run_frame(1'b0, 1'b0, 1'b0);
      checks++;
      if ({py, player_col} !== {10'd444, 4'b0000}) $display("FAIL jump_f21 got y=%0d col=%b expected y=444 col=0000", py, player_col);
      else passed++;
      run_frame(1'b0, 1'b0, 1'b0);
      checks++;
      if ({py, player_col} !== {10'd447, 4'b0010}) $display("FAIL jump_land got y=%0d col=%b expected y=447 col=0010", py, player_col);
      else passed++;
   endtask

   task automatic test_wall_right();
      clear_map();
      set_floor();
      map[13][3] = 3'd2;
      do_reset();
      repeat (16) run_frame(1'b0, 1'b1, 1'b0);
      checks++;
      if ({px, player_col} !== {10'd64, 4'b0010}) $display("FAIL wallr_approach got x=%0d col=%b expected x=64 col=0010", px, player_col);
      else passed++;
      run_frame(1'b0, 1'b1, 1'b0);
      checks++;
      if ({px, py, player_col} !== {10'd64, 10'd447, 4'b0110})
         $display("FAIL wallr_hit got x=%0d y=%0d col=%b expected x=64 y=447 col=0110", px, py, player_col);
      else passed++;
   endtask

   task automatic test_wall_left();
      clear_map();
      set_floor();
      map[13][0] = 3'd2;
      do_reset();
      run_frame(1'b1, 1'b0, 1'b0);
      checks++;
      if ({px, player_col} !== {10'd32, 4'b0011}) $display("FAIL walll_hit got x=%0d col=%b expected x=32 col=0011", px, player_col);
      else passed++;
   endtask

   task automatic test_clamp_left();
      clear_map();
      set_floor();
      do_reset();
      repeat (16) run_frame(1'b1, 1'b0, 1'b0);
      checks++;
      if ({px, player_col} !== {10'd0, 4'b0010}) $display("FAIL clamp_edge got x=%0d col=%b expected x=0 col=0010", px, player_col);
      else passed++;
      run_frame(1'b1, 1'b0, 1'b0);
      checks++;
      if ({px, player_col} !== {10'd0, 4'b0011}) $display("FAIL clamp_left got x=%0d col=%b expected x=0 col=0011", px, player_col);
      else passed++;
      run_frame(1'b1, 1'b1, 1'b0);
      checks++;
      if ({px, player_col} !== {10'd0, 4'b0010}) $display("FAIL both_btn got x=%0d col=%b expected x=0 col=0010", px, player_col);
      else passed++;
   endtask

   task automatic test_back_to_back();
      logic [12:0] req_seen;
      logic [12:0] busy_seen;
      logic [19:0] pos10;
      logic [19:0] pos11;
      clear_map();
      do_reset();
      req_seen = '0;
      busy_seen = '0;
      pos10 = '0;
      pos11 = '0;
      @(negedge clk);
      frame_start = 1'b1;
      req_seen[0] = tile_bus.tile_req;
      busy_seen[0] = busy;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         frame_start = (k == 5);
         req_seen[k] = tile_bus.tile_req;
         busy_seen[k] = busy;
         if (k == 10) pos10 = player_pos;
         if (k == 11) pos11 = player_pos;
      end
      frame_start = 1'b0;
      repeat (20) @(negedge clk);
      checks++;
      if (req_seen !== 13'h0CC) $display("FAIL b2b_req_pattern got %b expected %b", req_seen, 13'h0CC);
      else passed++;
      checks++;
      if (busy_seen !== 13'h7FE) $display("FAIL b2b_busy_pattern got %b expected %b", busy_seen, 13'h7FE);
      else passed++;
      checks++;
      if (pos10 !== {10'd32, 10'd447}) $display("FAIL b2b_pos_t10 got %h expected %h", pos10, {10'd32, 10'd447});
      else passed++;
      checks++;
      if (pos11 !== {10'd32, 10'd448}) $display("FAIL b2b_pos_t11 got %h expected %h", pos11, {10'd32, 10'd448});
      else passed++;
      checks++;
      if ({player_pos, busy} !== {10'd32, 10'd448, 1'b0}) $display("FAIL b2b_single_update got pos=%h busy=%b expected pos=%h busy=0", player_pos, busy, {10'd32, 10'd448});
      else passed++;
   endtask

   task automatic test_reset_midframe();
      clear_map();
      set_floor();
      do_reset();
      repeat (3) run_frame(1'b0, 1'b1, 1'b0);
      checks++;
      if ({px, player_col} !== {10'd38, 4'b0010}) $display("FAIL mid_pre got x=%0d col=%b expected x=38 col=0010", px, player_col);
      else passed++;
      @(negedge clk);
      btn_right = 1'b1;
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({player_pos, player_col, busy, tile_bus.tile_req} !== {10'd32, 10'd447, 4'b0000, 1'b0, 1'b0})
         $display("FAIL mid_reset got pos=%h col=%b busy=%b req=%b expected pos=%h col=0000 busy=0 req=0",
                  player_pos, player_col, busy, tile_bus.tile_req, {10'd32, 10'd447});
      else passed++;
      @(negedge clk);
      btn_right = 1'b0;
      rst_n = 1'b1;
      run_frame(1'b0, 1'b0, 1'b0);
      checks++;
      if ({player_pos, player_col} !== {10'd32, 10'd447, 4'b0010})
         $display("FAIL mid_after got pos=%h col=%b expected pos=%h col=0010", player_pos, player_col, {10'd32, 10'd447});
      else passed++;
   endtask

   initial begin
      clear_map();
      test_reset();
      test_freefall();
      test_walk_floor();
      test_jump();
      test_wall_right();
      test_wall_left();
      test_clamp_left();
      test_back_to_back();
      test_reset_midframe();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   // Guard against a stuck run.
   initial begin
      #2000000;
      $display("FAIL watchdog expired got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
